// File: rtl/xrv_dbus_axil.sv
// Core data-bus to AXI4-Lite master bridge: one outstanding load or store at a time,
// with a completion timeout that reports an error and then drains the abandoned bus transaction.
module xrv_dbus_axil #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [31:0] d_addr,
    input  logic        d_wr_req,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_wr_data,
    output logic        d_wr_ready,
    input  logic        d_rd_req,
    output logic        d_rd_ready,
    output logic [31:0] d_rd_data,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic        bus_err
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, ACK, DRAIN} state_t;

    state_t             state;
    logic               is_wr;
    logic               resp_owed;
    logic [CNT_W-1:0]   cnt;

    logic               aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic               aw_clear, w_clear;
    logic               busy, completing, tmo_hit;
    logic [CNT_W-1:0]   cnt_nxt;

    assign aw_hs    = m_awvalid & m_awready;
    assign w_hs     = m_wvalid & m_wready;
    assign ar_hs    = m_arvalid & m_arready;
    assign b_hs     = m_bvalid & m_bready;
    assign r_hs     = m_rvalid & m_rready;
    assign aw_clear = !m_awvalid || m_awready;
    assign w_clear  = !m_wvalid || m_wready;

    assign busy       = (state == WRITE) || (state == WRESP) || (state == READ) || (state == RDATA);
    assign completing = ((state == WRESP) && m_bvalid) || ((state == RDATA) && m_rvalid);
    assign cnt_nxt    = cnt + CNT_W'(1);
    assign tmo_hit    = (TIMEOUT != 0) && (cnt_nxt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            is_wr      <= 1'b0;
            resp_owed  <= 1'b0;
            cnt        <= '0;
            d_wr_ready <= 1'b0;
            d_rd_ready <= 1'b0;
            d_rd_data  <= '0;
            bus_err    <= 1'b0;
            m_awaddr   <= '0;
            m_awvalid  <= 1'b0;
            m_wdata    <= '0;
            m_wstrb    <= '0;
            m_wvalid   <= 1'b0;
            m_bready   <= 1'b0;
            m_araddr   <= '0;
            m_arvalid  <= 1'b0;
            m_rready   <= 1'b0;
        end else begin
            d_wr_ready <= 1'b0;
            d_rd_ready <= 1'b0;
            bus_err    <= 1'b0;

            // Channel bookkeeping is state-independent so ACK and DRAIN retire handshakes too.
            if (aw_hs) m_awvalid <= 1'b0;
            if (w_hs)  m_wvalid  <= 1'b0;
            if (ar_hs) m_arvalid <= 1'b0;
            if (b_hs) begin
                m_bready  <= 1'b0;
                resp_owed <= 1'b0;
            end
            if (r_hs) begin
                m_rready  <= 1'b0;
                resp_owed <= 1'b0;
            end
            if (busy) cnt <= cnt_nxt;

            case (state)
                IDLE: begin
                    if (d_rd_req) begin
                        m_araddr  <= d_addr;
                        m_arvalid <= 1'b1;
                        is_wr     <= 1'b0;
                        resp_owed <= 1'b1;
                        cnt       <= '0;
                        state     <= READ;
                    end else if (d_wr_req) begin
                        m_awaddr  <= d_addr;
                        m_wdata   <= d_wr_data;
                        m_wstrb   <= d_be;
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        is_wr     <= 1'b1;
                        resp_owed <= 1'b1;
                        cnt       <= '0;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (aw_clear && w_clear) begin
                        m_bready <= 1'b1;
                        state    <= WRESP;
                    end
                end
                WRESP: begin
                    if (m_bvalid) begin
                        d_wr_ready <= 1'b1;
                        bus_err    <= (m_bresp != 2'b00);
                        state      <= ACK;
                    end
                end
                READ: begin
                    if (ar_hs) begin
                        m_rready <= 1'b1;
                        state    <= RDATA;
                    end
                end
                RDATA: begin
                    if (m_rvalid) begin
                        d_rd_data  <= (m_rresp == 2'b00) ? m_rdata : 32'h0;
                        bus_err    <= (m_rresp != 2'b00);
                        d_rd_ready <= 1'b1;
                        state      <= ACK;
                    end
                end
                ACK: begin
                    state <= resp_owed ? DRAIN : IDLE;
                end
                DRAIN: begin
                    if (!resp_owed) begin
                        state <= IDLE;
                    end else if (is_wr) begin
                        if (aw_clear && w_clear && !b_hs) m_bready <= 1'b1;
                    end else begin
                        if ((!m_arvalid || m_arready) && !r_hs) m_rready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Timeout overrides any address/data-phase transition; a response arriving now still wins.
            if (busy && tmo_hit && !completing) begin
                state      <= ACK;
                bus_err    <= 1'b1;
                d_wr_ready <= is_wr;
                d_rd_ready <= !is_wr;
                if (!is_wr) d_rd_data <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_xrv_dbus_axil.sv
// Directed bench for xrv_dbus_axil: a latency-programmable AXI4-Lite slave model plus
// core-side load/store sequences with hand-computed expectations.
module tb_xrv_dbus_axil;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic [31:0] d_addr = '0;
    logic        d_wr_req = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_wr_data = '0;
    logic        d_rd_req = 1'b0;
    logic        d_wr_ready, d_rd_ready, bus_err;
    logic [31:0] d_rd_data;
    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic        m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
    logic        m_bvalid = 1'b0, m_rvalid = 1'b0;
    logic [1:0]  m_bresp = '0, m_rresp = '0;
    logic [31:0] m_rdata = '0;

    xrv_dbus_axil #(.TIMEOUT(8)) dut (
        .clk(clk), .rstb(rstb),
        .d_addr(d_addr), .d_wr_req(d_wr_req), .d_be(d_be), .d_wr_data(d_wr_data),
        .d_wr_ready(d_wr_ready), .d_rd_req(d_rd_req), .d_rd_ready(d_rd_ready), .d_rd_data(d_rd_data),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave model configuration (written by the stimulus process only)
    int          aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0, b_lat = 0;
    logic [31:0] rd_val = '0;
    logic [1:0]  rd_resp = '0, wr_resp = '0;

    int   aw_c = 0, w_c = 0, ar_c = 0, b_cd = -1, r_cd = -1;
    logic aw_seen = 1'b0, w_seen = 1'b0;
    logic s_aw_h, s_w_h, s_ar_h, s_b_h, s_r_h;

    always @(posedge clk) begin
        s_aw_h = m_awvalid && m_awready;
        s_w_h  = m_wvalid && m_wready;
        s_ar_h = m_arvalid && m_arready;
        s_b_h  = m_bvalid && m_bready;
        s_r_h  = m_rvalid && m_rready;
        #1;
        if (!rstb) begin
            m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
            m_bvalid = 1'b0; m_rvalid = 1'b0;
            aw_c = 0; w_c = 0; ar_c = 0; b_cd = -1; r_cd = -1;
            aw_seen = 1'b0; w_seen = 1'b0;
        end else begin
            if (s_aw_h) aw_seen = 1'b1;
            if (s_w_h)  w_seen = 1'b1;
            if (s_b_h)  m_bvalid = 1'b0;
            if (s_r_h)  m_rvalid = 1'b0;
            if (aw_seen && w_seen) begin
                aw_seen = 1'b0; w_seen = 1'b0; b_cd = b_lat;
            end
            if (s_ar_h) r_cd = r_lat;
            if (b_cd == 0) begin
                m_bvalid = 1'b1; m_bresp = wr_resp; b_cd = -1;
            end else if (b_cd > 0) b_cd--;
            if (r_cd == 0) begin
                m_rvalid = 1'b1; m_rdata = rd_val; m_rresp = rd_resp; r_cd = -1;
            end else if (r_cd > 0) r_cd--;
            aw_c = m_awvalid ? aw_c + 1 : 0;
            w_c  = m_wvalid  ? w_c + 1  : 0;
            ar_c = m_arvalid ? ar_c + 1 : 0;
            m_awready = m_awvalid && (aw_c > aw_lat);
            m_wready  = m_wvalid  && (w_c > w_lat);
            m_arready = m_arvalid && (ar_c > ar_lat);
        end
    end

    // Protocol monitor: handshake counts, captured payloads, valid-drop / payload-change violations
    int          n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0, n_rdr = 0, n_wdr = 0, n_viol = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
    logic [3:0]  last_wstrb = '0;
    logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;

    always @(negedge clk) begin
        if (!rstb) begin
            p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0;
        end else begin
            if (p_aw && (!m_awvalid || m_awaddr != p_awaddr)) n_viol++;
            if (p_w && (!m_wvalid || m_wdata != p_wdata)) n_viol++;
            if (p_ar && (!m_arvalid || m_araddr != p_araddr)) n_viol++;
            p_aw = m_awvalid && !m_awready; p_awaddr = m_awaddr;
            p_w  = m_wvalid && !m_wready;   p_wdata = m_wdata;
            p_ar = m_arvalid && !m_arready; p_araddr = m_araddr;
            if (m_awvalid && m_awready) begin n_aw++; last_awaddr = m_awaddr; end
            if (m_wvalid && m_wready) begin n_w++; last_wdata = m_wdata; last_wstrb = m_wstrb; end
            if (m_arvalid && m_arready) begin n_ar++; last_araddr = m_araddr; end
            if (m_bvalid && m_bready) n_b++;
            if (m_rvalid && m_rready) n_r++;
            if (d_rd_ready) n_rdr++;
            if (d_wr_ready) n_wdr++;
        end
    end

    task automatic wait_rd_ready(input string tag);
        int g = 0;
        @(negedge clk);
        while (!d_rd_ready && g < 60) begin @(negedge clk); g++; end
        check_val(tag, 32'(d_rd_ready), 32'd1);
    endtask

    task automatic wait_wr_ready(input string tag);
        int g = 0;
        @(negedge clk);
        while (!d_wr_ready && g < 60) begin @(negedge clk); g++; end
        check_val(tag, 32'(d_wr_ready), 32'd1);
    endtask

    task automatic core_read(input logic [31:0] a, input string tag,
                             output logic [31:0] dat, output logic err);
        @(posedge clk); #1;
        d_addr = a; d_rd_req = 1'b1;
        wait_rd_ready(tag);
        dat = d_rd_data; err = bus_err;
        d_rd_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic core_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] dat,
                              input string tag, output logic err);
        @(posedge clk); #1;
        d_addr = a; d_be = be; d_wr_data = dat; d_wr_req = 1'b1;
        wait_wr_ready(tag);
        err = bus_err;
        d_wr_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdat;
        logic        rerr;
        int b_aw, b_w, b_ar, b_r, b_rdr, b_wdr, g;

        // Reset with a load already requested; nothing may start until release
        ar_lat = 0; r_lat = 2; rd_val = 32'hCAFEF00D; rd_resp = 2'b00;
        d_addr = 32'h100; d_rd_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_ctl", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                                  d_rd_ready, d_wr_ready, bus_err}), 32'h0);
        check_val("rst_rdata", d_rd_data, 32'h0);
        check_val("rst_addr", m_awaddr | m_araddr | m_wdata, 32'h0);
        check_val("rst_strb", 32'(m_wstrb), 32'h0);
        @(posedge clk); #1 rstb = 1'b1;
        @(negedge clk);
        check_val("arvalid_pre", 32'(m_arvalid), 32'd0);
        @(negedge clk);
        check_val("arvalid_lat", 32'(m_arvalid), 32'd1);
        check_val("araddr", m_araddr, 32'h100);
        wait_rd_ready("rd1_done");
        check_val("rd1_data", d_rd_data, 32'hCAFEF00D);
        check_val("rd1_err", 32'(bus_err), 32'd0);
        d_rd_req = 1'b0;
        repeat (4) @(posedge clk); #1;
        check_val("rd1_pulses", 32'(n_rdr), 32'd1);
        check_val("rd1_no_restart", 32'(n_ar), 32'd1);

        // Store with wready three cycles ahead of awready
        aw_lat = 3; w_lat = 0; b_lat = 0; wr_resp = 2'b00;
        b_aw = n_aw; b_w = n_w; b_wdr = n_wdr;
        core_write(32'h204, 4'hC, 32'h12340000, "wr1_done", rerr);
        check_val("wr1_err", 32'(rerr), 32'd0);
        check_val("wr1_aw_hs", 32'(n_aw - b_aw), 32'd1);
        check_val("wr1_w_hs", 32'(n_w - b_w), 32'd1);
        check_val("wr1_awaddr", last_awaddr, 32'h204);
        check_val("wr1_wdata", last_wdata, 32'h12340000);
        check_val("wr1_wstrb", 32'(last_wstrb), 32'hC);
        check_val("wr1_pulses", 32'(n_wdr - b_wdr), 32'd1);
        check_val("rd_data_held", d_rd_data, 32'hCAFEF00D);

        // Read timeout, late response drained, queued store waits for the drain
        aw_lat = 0; ar_lat = 0; r_lat = 20; rd_val = 32'h77777777;
        b_r = n_r; b_rdr = n_rdr; b_aw = n_aw;
        @(posedge clk); #1;
        d_addr = 32'h10C; d_rd_req = 1'b1;
        wait_rd_ready("to_done");
        check_val("to_err", 32'(bus_err), 32'd1);
        check_val("to_data", d_rd_data, 32'h0);
        d_rd_req = 1'b0;
        d_addr = 32'h400; d_be = 4'hF; d_wr_data = 32'hA5A5A5A5; d_wr_req = 1'b1;
        repeat (3) @(negedge clk);
        check_val("drain_rready", 32'(m_rready), 32'd1);
        check_val("drain_no_aw", 32'(m_awvalid), 32'd0);
        g = 0;
        while (!m_awvalid && g < 60) begin @(negedge clk); g++; end
        check_val("store_started", 32'(m_awvalid), 32'd1);
        check_val("late_r_consumed", 32'(n_r - b_r), 32'd1);
        wait_wr_ready("queued_wr_done");
        d_wr_req = 1'b0;
        @(posedge clk); #1;
        check_val("late_discard", d_rd_data, 32'h0);
        check_val("to_pulses", 32'(n_rdr - b_rdr), 32'd1);
        check_val("queued_awaddr", last_awaddr, 32'h400);

        // Normal read after the timeout, then a read with SLVERR
        r_lat = 1; rd_val = 32'h55AA1234;
        core_read(32'h108, "rd2_done", rdat, rerr);
        check_val("rd2_data", rdat, 32'h55AA1234);
        check_val("rd2_err", 32'(rerr), 32'd0);
        check_val("rd2_araddr", last_araddr, 32'h108);
        r_lat = 0; rd_val = 32'hDEADBEEF; rd_resp = 2'b10;
        core_read(32'h10C, "rd3_done", rdat, rerr);
        check_val("rd3_data", rdat, 32'h0);
        check_val("rd3_err", 32'(rerr), 32'd1);
        rd_resp = 2'b00;

        // Zero byte-enable store still issues, with an error response
        wr_resp = 2'b10; b_w = n_w;
        core_write(32'h208, 4'h0, 32'hFFFF0000, "wr0_done", rerr);
        check_val("wr0_w_hs", 32'(n_w - b_w), 32'd1);
        check_val("wr0_wstrb", 32'(last_wstrb), 32'h0);
        check_val("wr0_err", 32'(rerr), 32'd1);
        wr_resp = 2'b00;

        // Simultaneous load and store: load goes first
        rd_val = 32'h0BADF00D; b_aw = n_aw; b_ar = n_ar;
        @(posedge clk); #1;
        d_addr = 32'h300; d_be = 4'h3; d_wr_data = 32'h11112222;
        d_rd_req = 1'b1; d_wr_req = 1'b1;
        g = 0;
        @(negedge clk);
        while (!m_arvalid && !m_awvalid && g < 20) begin @(negedge clk); g++; end
        check_val("prio_first", 32'({m_arvalid, m_awvalid}), 32'h2);
        wait_rd_ready("prio_rd_done");
        check_val("prio_rd_data", d_rd_data, 32'h0BADF00D);
        check_val("prio_no_aw_yet", 32'(n_aw - b_aw), 32'd0);
        d_rd_req = 1'b0;
        wait_wr_ready("prio_wr_done");
        d_wr_req = 1'b0;
        @(posedge clk); #1;
        check_val("prio_aw_hs", 32'(n_aw - b_aw), 32'd1);
        check_val("prio_ar_hs", 32'(n_ar - b_ar), 32'd1);
        check_val("prio_wdata", last_wdata, 32'h11112222);

        // Reset asserted while waiting for the write response
        b_lat = 6; b_wdr = n_wdr;
        @(posedge clk); #1;
        d_addr = 32'h500; d_be = 4'hF; d_wr_data = 32'h99998888; d_wr_req = 1'b1;
        g = 0;
        @(negedge clk);
        while (!m_bready && g < 30) begin @(negedge clk); g++; end
        check_val("wresp_reached", 32'(m_bready), 32'd1);
        #1 rstb = 1'b0;
        #1;
        check_val("mid_rst_ctl", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                                      d_rd_ready, d_wr_ready, bus_err}), 32'h0);
        check_val("mid_rst_data", m_awaddr | m_wdata | m_araddr | d_rd_data | 32'(m_wstrb), 32'h0);
        d_wr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstb = 1'b1;
        repeat (15) @(negedge clk);
        check_val("mid_rst_no_ack", 32'(n_wdr - b_wdr), 32'd0);
        check_val("mid_rst_idle", 32'({m_awvalid, m_arvalid, m_bready}), 32'h0);

        check_val("protocol_viol", 32'(n_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
